// File: rtl/bp_cce_dir_sched_pkg.sv
// Shared types for the CCE directory scheduler: directory op and coherence
// state encodings, scheduler FSM states and small helper functions.
package bp_cce_dir_sched_pkg;

  localparam int dir_op_width_lp = 3;
  localparam int coh_width_lp    = 3;

  typedef enum logic [dir_op_width_lp-1:0] {
    e_rdw_op = 3'd0,
    e_rde_op = 3'd1,
    e_wdp_op = 3'd2,
    e_clr_op = 3'd3,
    e_wde_op = 3'd4,
    e_wds_op = 3'd5,
    e_gad_op = 3'd6
  } bp_cce_inst_minor_dir_op_e;

  typedef enum logic [coh_width_lp-1:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_M = 3'd4,
    e_COH_O = 3'd5
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_dir_sched_init    = 2'd0,
    e_dir_sched_ready   = 2'd1,
    e_dir_sched_wait_rd = 2'd2
  } bp_cce_dir_sched_state_e;

  function automatic logic is_dir_read(input logic [dir_op_width_lp-1:0] cmd);
    return (cmd == e_rdw_op) || (cmd == e_rde_op);
  endfunction

  // Width of a counter/index covering 0..x-1; never narrower than one bit.
  function automatic int safe_clog2(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: grants the first request at or after a one-hot
// pointer, which then moves just past the winner on every grant.
module bsg_arb_round_robin #(
  parameter int width_p = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_en,
  input  logic [width_p-1:0] i_reqs,
  output logic [width_p-1:0] o_grants
);

  logic [width_p-1:0] w_ptr_oh;
  logic [width_p-1:0] w_hi;
  logic [width_p-1:0] w_pick;
  logic [width_p-1:0] w_raw;

  // Requests at or above the pointer win; otherwise wrap to the lowest one.
  always_comb begin
    w_hi     = i_reqs & ~(w_ptr_oh - 1'b1);
    w_pick   = (|w_hi) ? w_hi : i_reqs;
    w_raw    = w_pick & (~w_pick + 1'b1);
    o_grants = i_en ? w_raw : '0;
  end

  generate
    if (width_p == 1) begin : g_single
      assign w_ptr_oh = 1'b1;
    end else begin : g_multi
      logic [width_p-1:0] r_ptr_oh;
      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          r_ptr_oh <= {{(width_p-1){1'b0}}, 1'b1};
        end else if (|o_grants) begin
          r_ptr_oh <= {o_grants[width_p-2:0], o_grants[width_p-1]};
        end
      end
      assign w_ptr_oh = r_ptr_oh;
    end
  endgenerate

endmodule

// File: rtl/bp_cce_dir_sched.sv
// CCE directory scheduler: sweeps the directory to invalid after reset, then
// shares it among requesters one op at a time, holding off behind reads.
module bp_cce_dir_sched
  import bp_cce_dir_sched_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int paddr_width_p     = 40,
  parameter int lce_id_width_p    = 4,
  parameter int lce_assoc_width_p = 3,
  parameter int num_lce_p         = 4,
  parameter int dir_sets_p        = 64,
  parameter int lce_assoc_p       = 8,
  parameter int block_offset_p    = 6
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  input  logic [num_req_p*dir_op_width_lp-1:0]   req_cmd_i,
  input  logic [num_req_p*paddr_width_p-1:0]     req_addr_i,
  input  logic [num_req_p*lce_id_width_p-1:0]    req_lce_i,
  input  logic [num_req_p*lce_assoc_width_p-1:0] req_way_i,
  input  logic [num_req_p*coh_width_lp-1:0]      req_coh_state_i,
  output logic [num_req_p-1:0]                   resp_v_o,
  output logic                                   init_done_o,
  output logic                                   dir_r_v_o,
  output logic                                   dir_w_v_o,
  output logic [dir_op_width_lp-1:0]             dir_cmd_o,
  output logic [paddr_width_p-1:0]               dir_addr_o,
  output logic [lce_id_width_p-1:0]              dir_lce_o,
  output logic [lce_assoc_width_p-1:0]           dir_way_o,
  output logic [coh_width_lp-1:0]                dir_coh_state_o,
  input  logic                                   dir_busy_i
);

  localparam int set_w_lp = safe_clog2(dir_sets_p);
  localparam int lce_w_lp = safe_clog2(num_lce_p);
  localparam int way_w_lp = safe_clog2(lce_assoc_p);

  localparam logic [set_w_lp-1:0] set_last_lp = set_w_lp'(dir_sets_p - 1);
  localparam logic [lce_w_lp-1:0] lce_last_lp = lce_w_lp'(num_lce_p - 1);
  localparam logic [way_w_lp-1:0] way_last_lp = way_w_lp'(lce_assoc_p - 1);

  bp_cce_dir_sched_state_e r_state;
  logic [set_w_lp-1:0]     r_set;
  logic [lce_w_lp-1:0]     r_lce;
  logic [way_w_lp-1:0]     r_way;
  logic [num_req_p-1:0]    r_owner;
  logic                    r_init_done;

  logic                          w_arb_en;
  logic [num_req_p-1:0]          w_grants;
  logic                          w_any_grant;
  logic                          w_g_read;
  logic [dir_op_width_lp-1:0]    w_g_cmd;
  logic [paddr_width_p-1:0]      w_g_addr;
  logic [lce_id_width_p-1:0]     w_g_lce;
  logic [lce_assoc_width_p-1:0]  w_g_way;
  logic [coh_width_lp-1:0]       w_g_coh;
  logic [paddr_width_p-1:0]      w_sweep_addr;

  assign w_arb_en = reset_n_i && (r_state == e_dir_sched_ready) && !dir_busy_i;

  bsg_arb_round_robin #(
    .width_p (num_req_p)
  ) u_arb (
    .i_clk     (clk_i),
    .i_reset_n (reset_n_i),
    .i_en      (w_arb_en),
    .i_reqs    (req_v_i),
    .o_grants  (w_grants)
  );

  // The grant is one-hot, so OR-ing the masked requester fields selects the winner.
  always_comb begin
    w_g_cmd  = '0;
    w_g_addr = '0;
    w_g_lce  = '0;
    w_g_way  = '0;
    w_g_coh  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (w_grants[i]) begin
        w_g_cmd  = w_g_cmd  | req_cmd_i[i*dir_op_width_lp +: dir_op_width_lp];
        w_g_addr = w_g_addr | req_addr_i[i*paddr_width_p +: paddr_width_p];
        w_g_lce  = w_g_lce  | req_lce_i[i*lce_id_width_p +: lce_id_width_p];
        w_g_way  = w_g_way  | req_way_i[i*lce_assoc_width_p +: lce_assoc_width_p];
        w_g_coh  = w_g_coh  | req_coh_state_i[i*coh_width_lp +: coh_width_lp];
      end
    end
    w_any_grant = |w_grants;
    w_g_read    = is_dir_read(w_g_cmd);
  end

  always_comb begin
    w_sweep_addr = '0;
    w_sweep_addr[block_offset_p +: set_w_lp] = r_set;
  end

  // Every output is forced quiet while reset is asserted.
  always_comb begin
    dir_r_v_o       = 1'b0;
    dir_w_v_o       = 1'b0;
    dir_cmd_o       = e_rdw_op;
    dir_addr_o      = '0;
    dir_lce_o       = '0;
    dir_way_o       = '0;
    dir_coh_state_o = e_COH_I;
    resp_v_o        = '0;
    if (reset_n_i) begin
      case (r_state)
        e_dir_sched_init: begin
          dir_w_v_o  = !dir_busy_i;
          dir_cmd_o  = e_wde_op;
          dir_addr_o = w_sweep_addr;
          dir_lce_o  = lce_id_width_p'(r_lce);
          dir_way_o  = lce_assoc_width_p'(r_way);
        end
        e_dir_sched_ready: begin
          if (w_any_grant) begin
            dir_r_v_o       = w_g_read;
            dir_w_v_o       = !w_g_read;
            dir_cmd_o       = w_g_cmd;
            dir_addr_o      = w_g_addr;
            dir_lce_o       = w_g_lce;
            dir_way_o       = w_g_way;
            dir_coh_state_o = w_g_coh;
          end
        end
        e_dir_sched_wait_rd: begin
          resp_v_o = dir_busy_i ? '0 : r_owner;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = w_grants;
  assign init_done_o = r_init_done & reset_n_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= e_dir_sched_init;
      r_set       <= '0;
      r_lce       <= '0;
      r_way       <= '0;
      r_owner     <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        e_dir_sched_init: begin
          // Way is the innermost counter, then LCE, then set.
          if (!dir_busy_i) begin
            if (r_way != way_last_lp) begin
              r_way <= r_way + 1'b1;
            end else begin
              r_way <= '0;
              if (r_lce != lce_last_lp) begin
                r_lce <= r_lce + 1'b1;
              end else begin
                r_lce <= '0;
                if (r_set != set_last_lp) begin
                  r_set <= r_set + 1'b1;
                end else begin
                  r_set       <= '0;
                  r_state     <= e_dir_sched_ready;
                  r_init_done <= 1'b1;
                end
              end
            end
          end
        end
        e_dir_sched_ready: begin
          if (w_any_grant && w_g_read) begin
            r_owner <= w_grants;
            r_state <= e_dir_sched_wait_rd;
          end
        end
        e_dir_sched_wait_rd: begin
          if (!dir_busy_i) begin
            r_state <= e_dir_sched_ready;
          end
        end
        default: r_state <= e_dir_sched_init;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cce_dir_sched.sv
// Bench for bp_cce_dir_sched with a 4-set x 2-LCE x 2-way directory and two
// requesters; directed scenarios followed by a randomized run against a model.
module tb_bp_cce_dir_sched;

  localparam int NR = 2, PA = 40, LI = 4, LW = 3;
  localparam int NL = 2, DS = 4, LA = 2, BO = 6;
  localparam int TOTAL = DS * NL * LA;
  localparam logic [2:0] OP_RDW = 3'd0, OP_RDE = 3'd1, OP_WDE = 3'd4, OP_WDS = 3'd5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req_v = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*3-1:0] req_cmd = '0;
  logic [NR*PA-1:0] req_addr = '0;
  logic [NR*LI-1:0] req_lce = '0;
  logic [NR*LW-1:0] req_way = '0;
  logic [NR*3-1:0] req_coh = '0;
  logic [NR-1:0]   resp_v;
  logic            init_done, dir_r_v, dir_w_v, busy = 1'b0;
  logic [2:0]      dir_cmd, dir_coh;
  logic [PA-1:0]   dir_addr;
  logic [LI-1:0]   dir_lce;
  logic [LW-1:0]   dir_way;
  logic [59:0]     obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_cce_dir_sched #(
    .num_req_p(NR), .paddr_width_p(PA), .lce_id_width_p(LI), .lce_assoc_width_p(LW),
    .num_lce_p(NL), .dir_sets_p(DS), .lce_assoc_p(LA), .block_offset_p(BO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_ready_o(req_ready),
    .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_lce_i(req_lce), .req_way_i(req_way),
    .req_coh_state_i(req_coh), .resp_v_o(resp_v), .init_done_o(init_done),
    .dir_r_v_o(dir_r_v), .dir_w_v_o(dir_w_v), .dir_cmd_o(dir_cmd), .dir_addr_o(dir_addr),
    .dir_lce_o(dir_lce), .dir_way_o(dir_way), .dir_coh_state_o(dir_coh), .dir_busy_i(busy)
  );

  assign obs = {req_ready, resp_v, dir_r_v, dir_w_v, init_done,
                dir_cmd, dir_addr, dir_lce, dir_way, dir_coh};

  function automatic logic [52:0] req_fields(input int g);
    return {req_cmd[g*3 +: 3], req_addr[g*PA +: PA], req_lce[g*LI +: LI],
            req_way[g*LW +: LW], req_coh[g*3 +: 3]};
  endfunction

  task automatic set_req(input int i, input logic [2:0] cmd, input logic [PA-1:0] addr,
                         input logic [LI-1:0] lce, input logic [LW-1:0] way, input logic [2:0] coh);
    req_cmd[i*3 +: 3]   = cmd;
    req_addr[i*PA +: PA] = addr;
    req_lce[i*LI +: LI] = lce;
    req_way[i*LW +: LW] = way;
    req_coh[i*3 +: 3]   = coh;
  endtask

  // Releases reset in cycle 1 and follows the whole sweep to init_done.
  task automatic run_sweep(input string name, input int bs, input int bl);
    int k = 0;
    bit done = 0;
    logic [59:0] exp;
    logic [PA-1:0] a;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      reset_n = 1'b1;
      req_v   = '0;
      busy    = (cyc >= bs) && (cyc < bs + bl);
      #1;
      if (k < TOTAL) begin
        a = '0;
        a = PA'(k / (LA * NL)) << BO;
        exp = {2'b00, 2'b00, 1'b0, !busy, 1'b0, OP_WDE, a,
               LI'((k / LA) % NL), LW'(k % LA), 3'd0};
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL %s write %0d cycle %0d: got %h want %h", name, k, cyc, obs, exp);
        end
        if (!busy) k++;
      end else begin
        done = 1;
        exp = {7'b0000001, 53'd0};
        n_vec++;
        if (obs !== exp || cyc != TOTAL + 1 + bl) begin
          n_err++;
          $display("FAIL %s done: cycle %0d got %h want cycle %0d %h", name, cyc, obs, TOTAL + 1 + bl, exp);
        end
      end
    end
    busy = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: init_done never seen, %0d writes", name, k);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_v   = 2'b11;
    set_req(0, OP_WDS, 40'h1234, 4'd1, 3'd1, 3'd1);
    set_req(1, OP_RDW, 40'h5678, 4'd2, 3'd2, 3'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (obs !== 60'd0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", c, obs);
      end
    end
  endtask

  task automatic test_init_busy();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    run_sweep("init_busy", 6, 3);
  endtask

  task automatic test_rr_writes();
    logic [59:0] exp;
    int g;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      busy  = 1'b0;
      req_v = 2'b11;
      set_req(0, OP_WDS, 40'h00_1234_5640, 4'd1, 3'd2, 3'd1);
      set_req(1, OP_WDS, 40'hAB_CDEF_0080, 4'd2, 3'd5, 3'd2);
      #1;
      g = c % 2;
      exp = {2'(1 << g), 2'b00, 1'b0, 1'b1, 1'b1, req_fields(g)};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL rr_writes grant %0d: got %h want %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_read_wait();
    logic [59:0] exp [5];
    @(negedge clk);
    busy  = 1'b0;
    req_v = 2'b10;
    set_req(1, OP_RDW, 40'h33_0000_0C40, 4'd3, 3'd4, 3'd0);
    #1;
    exp[0] = {2'b10, 2'b00, 1'b1, 1'b0, 1'b1, req_fields(1)};
    n_vec++;
    if (obs !== exp[0]) begin
      n_err++;
      $display("FAIL read_issue: got %h want %h", obs, exp[0]);
    end
    set_req(0, OP_WDE, 40'h01_0203_0400, 4'd5, 3'd6, 3'd4);
    exp[1] = {7'b0000001, 53'd0};
    exp[2] = exp[1];
    exp[3] = {2'b00, 2'b10, 3'b001, 53'd0};
    exp[4] = {2'b01, 2'b00, 1'b0, 1'b1, 1'b1, req_fields(0)};
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      req_v = 2'b01;
      busy  = (c < 3);
      #1;
      n_vec++;
      if (obs !== exp[c]) begin
        n_err++;
        $display("FAIL read_wait cycle %0d after grant: got %h want %h", c, obs, exp[c]);
      end
    end
  endtask

  task automatic test_idle();
    logic [59:0] exp;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_v = 2'b00;
      busy  = 1'b0;
      #1;
      n_vec++;
      if (obs !== {7'b0000001, 53'd0}) begin
        n_err++;
        $display("FAIL idle cycle %0d: got %h want only init_done", c, obs);
      end
    end
    @(negedge clk);
    req_v = 2'b11;
    set_req(0, OP_WDS, 40'h0F_0000_0000, 4'd0, 3'd0, 3'd1);
    set_req(1, OP_WDE, 40'h0E_0000_0040, 4'd1, 3'd1, 3'd2);
    #1;
    exp = {2'b10, 2'b00, 1'b0, 1'b1, 1'b1, req_fields(1)};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL idle_pointer_kept: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_reset_wait_rd();
    logic [59:0] exp;
    @(negedge clk);
    req_v = 2'b01;
    set_req(0, OP_RDE, 40'h77_0000_1000, 4'd2, 3'd3, 3'd0);
    #1;
    exp = {2'b01, 2'b00, 1'b1, 1'b0, 1'b1, req_fields(0)};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL rst_wait_issue: got %h want %h", obs, exp);
    end
    @(negedge clk);
    req_v = 2'b00;
    busy  = 1'b1;
    #1;
    n_vec++;
    if (obs !== {7'b0000001, 53'd0}) begin
      n_err++;
      $display("FAIL rst_wait_busy: got %h want only init_done", obs);
    end
    @(negedge clk);
    reset_n = 1'b0;
    busy    = 1'b0;
    #1;
    n_vec++;
    if (obs !== 60'd0) begin
      n_err++;
      $display("FAIL rst_wait_in_reset: got %h want 0", obs);
    end
    run_sweep("rst_wait_resweep", 0, 0);
  endtask

  // Model: rotating priority from m_ptr; a granted read blocks until a non-busy cycle.
  task automatic test_random();
    int m_ptr = 0, m_owner = 0, g;
    bit m_wait = 0;
    bit hold [NR];
    logic [59:0] exp;
    logic [1:0] e_ready, e_resp;
    logic e_r, e_w;
    logic [52:0] e_f;
    logic [63:0] rnd;
    logic [2:0] cmd;
    for (int i = 0; i < NR; i++) hold[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!hold[i]) begin
          req_v[i] = ($urandom_range(0, 9) < 6);
          rnd = {$urandom(), $urandom()};
          cmd = (rnd[1:0] < 2'd2) ? {1'b0, rnd[1:0]} : {1'b1, rnd[1:0] - 2'd2};
          set_req(i, cmd, rnd[45:6], rnd[49:46], rnd[52:50], 3'(rnd[55:53] % 3'd6));
        end
      end
      busy = ($urandom_range(0, 3) == 0);
      e_ready = '0; e_resp = '0; e_r = 0; e_w = 0; e_f = '0;
      if (m_wait) begin
        if (!busy) begin
          e_resp[m_owner] = 1'b1;
          m_wait = 0;
        end
      end else if (!busy && (req_v != 0)) begin
        g = m_ptr;
        while (!req_v[g]) g = (g + 1) % NR;
        e_ready[g] = 1'b1;
        e_f = req_fields(g);
        e_r = (e_f[52:50] == OP_RDW) || (e_f[52:50] == OP_RDE);
        e_w = !e_r;
        m_ptr = (g + 1) % NR;
        if (e_r) begin
          m_wait  = 1;
          m_owner = g;
        end
      end
      for (int i = 0; i < NR; i++) hold[i] = req_v[i] && !e_ready[i];
      exp = {e_ready, e_resp, e_r, e_w, 1'b1, e_f};
      #1;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL random cycle %0d: got %h want %h", c, obs, exp);
      end
    end
    req_v = '0;
  endtask

  initial begin
    test_reset();
    run_sweep("init_sweep", 0, 0);
    test_init_busy();
    test_rr_writes();
    test_read_wait();
    test_idle();
    test_reset_wait_rd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
